truth_table_sweep: RTL
======================

# truth_table_sweep

- Sequential stimulus-and-capture stage wrapped around a combinational boolean function under test (FUT).
- Steps the FUT inputs through every combination in ascending binary order, counting from all-zeros to all-ones.
- Waits a programmable settle time on each combination, samples the FUT output and builds the minterm vector plus a ones count.
- Sits directly upstream of the FUT, driving its inputs, and directly downstream of it, consuming its output.

## Interface
- N_IN, default 3: number of FUT inputs. Legal range 1..8.
- SETTLE, default 1: extra cycles each vector is held before sampling. Legal range 0..15.
- clk  in  1  clock. Every register updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- start  in  1  sweep request. Sampled on the clock edge.
- vec  out  N_IN  current input combination to the FUT. vec[N_IN-1] is the first variable (x), vec[0] the last.
- f  in  1  FUT output, combinationally derived from vec.
- busy  out  1  high while the sweep runs.
- done  out  1  high from sweep completion until the next accepted start or rst.
- minterms  out  2**N_IN  bit i holds f sampled while vec==i.
- ones  out  N_IN+1  number of set bits in minterms.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN: on start=1. On that edge: vec<=0, cnt<=0, minterms<=0, ones<=0, busy<=1, done<=0.
- RUN, cnt<SETTLE: cnt<=cnt+1. vec is held.
- RUN, cnt==SETTLE: minterms[vec]<=f, ones<=ones+f, cnt<=0.
  - If vec==2**N_IN-1: go to DONE with busy<=0, done<=1, vec<=0.
  - Otherwise: vec<=vec+1.
- DONE: outputs held. On start=1, same actions as the IDLE start, and the FSM goes to RUN.
- start while in RUN is ignored. No queuing, no restart.
- Width rule: ones is N_IN+1 bits wide, so the all-ones case (2**N_IN) does not overflow.
- The vec increment never wraps inside a sweep; the terminal vector ends the sweep.
- rst has priority over start and over every FSM action.
- rst in any state, including mid-sweep: next edge gives state=IDLE, vec=0, cnt=0, minterms=0, ones=0, busy=0, done=0. Partial results are discarded.

## Timing
- Reset values: vec=0, busy=0, done=0, minterms=0, ones=0.
- Each vector is held for SETTLE+1 cycles. The sample is taken on the last edge of that window.
- Latency: done rises (SETTLE+1)*2**N_IN edges after the edge that accepted start.
  - N_IN=3, SETTLE=1: 16 edges.
  - SETTLE=0: 8 edges.
- busy falls on the same edge that done rises.
- minterms and ones are final and stable while done=1.
- Back-to-back sweeps: start held high in DONE restarts on the very next edge, giving zero idle cycles.

## Configuration
- Macro: TT_COMPARE_EN.
- Defined:
  - Adds port expect, input, 2**N_IN, the reference minterm vector.
  - Adds port match, output, 1. match=1 while done=1 and minterms==expect, else 0.
  - match is registered on the completion edge and clears on rst or an accepted start.
- Undefined: neither port exists, and no compare logic is built.

## Structure
- Shared package tt_pkg holds:
  - state encoding constants TT_IDLE=2'd0, TT_RUN=2'd1, TT_DONE=2'd2;
  - the limits TT_MAX_N_IN=8 and TT_MAX_SETTLE=15.
- One sub-module, tt_settle_cnt:
  - 4-bit counter with load-zero and enable;
  - outputs a terminal flag when cnt==SETTLE.
- The FSM, vec register, minterm capture and ones accumulator stay in the top module.

## Test plan
- Test 1, reference function: N_IN=3, SETTLE=1, f=(x|~y)&(~y|~z) with x=vec[2], y=vec[1], z=vec[0]. Pulse start -> done at +16 edges, minterms=8'h73, ones=4'd5, busy low at done.
- Test 2, constant FUT: SETTLE=0, f tied to 1 -> done at +8 edges, minterms=8'hFF, ones=4'd8 (no overflow). f tied to 0 -> minterms=8'h00, ones=0.
- Test 3, vec sequence: SETTLE=2.
  - vec holds each value for 3 cycles, steps 0..7 with no skips or repeats.
  - vec returns to 0 in DONE.
- Test 4, mid-sweep reset: assert rst at edge 5 of a sweep -> all outputs 0, state IDLE. A fresh start then yields a correct 8'h73.
- Test 5, start handling:
  - start held high throughout RUN -> no restart, done at +16;
  - start still high in DONE -> new sweep on the next edge, done cleared, minterms cleared.
- Test 6, compare (TT_COMPARE_EN defined): expect=8'h73 -> match=1 at done. expect=8'h72 -> match=0. match clears on the next accepted start.

Source files
------------

// File: rtl/truth_table_sweep_pkg.sv
// Shared constants for truth_table_sweep: FSM state encoding and parameter limits.
package tt_pkg;
   typedef logic [1:0] tt_state_t;

   localparam tt_state_t TT_IDLE = 2'd0;
   localparam tt_state_t TT_RUN  = 2'd1;
   localparam tt_state_t TT_DONE = 2'd2;

   localparam int unsigned TT_MAX_N_IN   = 8;
   localparam int unsigned TT_MAX_SETTLE = 15;
   localparam int unsigned TT_CNT_W      = $clog2(TT_MAX_SETTLE + 1);
endpackage

// File: rtl/truth_table_sweep_if.sv
// Stimulus/capture bus between truth_table_sweep and its surroundings.
// TT_COMPARE_EN adds the reference vector (expected) and the match flag.
interface truth_table_sweep_if #(
   parameter int N_IN = 3
);
   logic                 start;
   logic [N_IN-1:0]      vec;
   logic                 f;
   logic                 busy;
   logic                 done;
   logic [2**N_IN-1:0]   minterms;
   logic [N_IN:0]        ones;
`ifdef TT_COMPARE_EN
   logic [2**N_IN-1:0]   expected;
   logic                 match;

   modport master (output start, f, expected, input vec, busy, done, minterms, ones, match);
   modport slave  (input start, f, expected, output vec, busy, done, minterms, ones, match);
`else
   modport master (output start, f, input vec, busy, done, minterms, ones);
   modport slave  (input start, f, output vec, busy, done, minterms, ones);
`endif
endinterface

// File: rtl/truth_table_sweep_settle_cnt.sv
// Settle-time counter: clears on i_clr, counts on i_en, flags cnt==SETTLE.
module tt_settle_cnt
   import tt_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_term
);
   logic [TT_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + {{(TT_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_term = (r_cnt == TT_CNT_W'(SETTLE));
endmodule

// File: rtl/truth_table_sweep.sv
// Truth-table sweep: walks vec 0..2**N_IN-1, samples f after SETTLE extra cycles.
// Optional macro TT_COMPARE_EN adds a registered compare against bus.expected.
module truth_table_sweep
   import tt_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input logic               clk,
   input logic               rst,
   truth_table_sweep_if.slave bus
);
   localparam int NV = 2**N_IN;

   tt_state_t       r_state;
   logic [N_IN-1:0] r_vec;
   logic [NV-1:0]   r_minterms;
   logic [N_IN:0]   r_ones;
   logic            r_busy;
   logic            r_done;

   logic            w_term;
   logic            w_run;
   logic            w_accept;
   logic            w_sample;
   logic            w_last;
   logic [NV-1:0]   w_mt_next;
   logic [N_IN:0]   w_ones_next;

   // Start is honoured in IDLE and DONE only; a request during RUN is dropped.
   assign w_run       = (r_state == TT_RUN);
   assign w_accept    = !w_run && bus.start;
   assign w_sample    = w_run && w_term;
   assign w_last      = &r_vec;
   assign w_ones_next = r_ones + {{N_IN{1'b0}}, bus.f};

   always_comb begin
      w_mt_next        = r_minterms;
      w_mt_next[r_vec] = bus.f;
   end

   tt_settle_cnt #(
      .SETTLE (SETTLE)
   ) u_settle_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_accept || w_sample),
      .i_en   (w_run && !w_term),
      .o_term (w_term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= TT_IDLE;
         r_vec      <= '0;
         r_minterms <= '0;
         r_ones     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else if (w_accept) begin
         r_state    <= TT_RUN;
         r_vec      <= '0;
         r_minterms <= '0;
         r_ones     <= '0;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
      end else if (w_sample) begin
         r_minterms <= w_mt_next;
         r_ones     <= w_ones_next;
         if (w_last) begin
            r_state <= TT_DONE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
         end else begin
            r_vec   <= r_vec + N_IN'(1);
         end
      end
   end

   assign bus.vec      = r_vec;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.minterms = r_minterms;
   assign bus.ones     = r_ones;

`ifdef TT_COMPARE_EN
   logic r_match;

   // Judged on the completion edge using the minterm vector as it is being finalised.
   always_ff @(posedge clk) begin
      if (rst || w_accept) begin
         r_match <= 1'b0;
      end else if (w_sample && w_last) begin
         r_match <= (w_mt_next == bus.expected);
      end
   end

   assign bus.match = r_match;
`endif
endmodule
